// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one ALU op at a time, holds operands until ready_i, registers the response.
// Optional macro ALU_OP_ISSUER_STATS_EN adds op/busy/timeout statistic counters.
module alu_op_issuer #(
  parameter int ALU_OP_WIDTH = 7,
  parameter int MAX_WAIT     = 64,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] req_op_i,
  input  logic [31:0]             req_a_i,
  input  logic [31:0]             req_b_i,
  input  logic [31:0]             req_c_i,
  input  logic [1:0]              req_vector_mode_i,
  input  logic [4:0]              req_bmask_a_i,
  input  logic [4:0]              req_bmask_b_i,
  input  logic [1:0]              req_imm_vec_ext_i,
  input  logic [3:0]              req_clpx_i,
  output logic                    enable_o,
  output logic [ALU_OP_WIDTH-1:0] operator_o,
  output logic [31:0]             operand_a_o,
  output logic [31:0]             operand_b_o,
  output logic [31:0]             operand_c_o,
  output logic [1:0]              vector_mode_o,
  output logic [4:0]              bmask_a_o,
  output logic [4:0]              bmask_b_o,
  output logic [1:0]              imm_vec_ext_o,
  output logic                    is_clpx_o,
  output logic                    is_subrot_o,
  output logic [1:0]              clpx_shift_o,
  output logic                    ex_ready_o,
  input  logic [31:0]             result_i,
  input  logic                    comparison_result_i,
  input  logic                    ready_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_result_o,
  output logic                    rsp_cmp_o,
  output logic [ALU_OP_WIDTH-1:0] rsp_op_o,
  output logic [CNT_WIDTH-1:0]    rsp_cycles_o,
`ifdef ALU_OP_ISSUER_STATS_EN
  output logic                    rsp_timeout_o,
  output logic [31:0]             stat_ops_o,
  output logic [31:0]             stat_busy_o,
  output logic [15:0]             stat_timeouts_o
`else
  output logic                    rsp_timeout_o
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam logic [31:0] CMAX = (32'd1 << CNT_WIDTH) - 32'd1;
  localparam logic [31:0] MAXW = 32'(MAX_WAIT);
  state_e                  state_q;
  logic [ALU_OP_WIDTH-1:0] operator_q, rsp_op_q;
  logic [31:0]             operand_a_q, operand_b_q, operand_c_q, rsp_result_q;
  logic [1:0]              vector_mode_q, imm_vec_ext_q;
  logic [4:0]              bmask_a_q, bmask_b_q;
  logic [3:0]              clpx_q;
  logic                    rsp_cmp_q, rsp_timeout_q;
  logic [CNT_WIDTH-1:0]    rsp_cycles_q, cycles_d;
  logic [31:0]             wait_q, wait_d;
  logic                    done, timeout;
  assign wait_d   = wait_q + 32'd1;
  assign cycles_d = CNT_WIDTH'(wait_d > CMAX ? CMAX : wait_d);
  assign timeout  = state_q == EXEC && !ready_i && wait_d == MAXW;
  assign done     = state_q == EXEC && (ready_i || wait_d == MAXW);
  // rst_n gates ready so nothing is accepted while reset is held
  assign req_ready_o   = rst_n && state_q == IDLE;
  assign enable_o      = state_q == EXEC;
  assign ex_ready_o    = enable_o && ready_i;
  assign rsp_valid_o   = state_q == RESP;
  assign operator_o    = operator_q;
  assign operand_a_o   = operand_a_q;
  assign operand_b_o   = operand_b_q;
  assign operand_c_o   = operand_c_q;
  assign vector_mode_o = vector_mode_q;
  assign bmask_a_o     = bmask_a_q;
  assign bmask_b_o     = bmask_b_q;
  assign imm_vec_ext_o = imm_vec_ext_q;
  assign is_clpx_o     = clpx_q[3];
  assign is_subrot_o   = clpx_q[2];
  assign clpx_shift_o  = clpx_q[1:0];
  assign rsp_result_o  = rsp_result_q;
  assign rsp_cmp_o     = rsp_cmp_q;
  assign rsp_op_o      = rsp_op_q;
  assign rsp_cycles_o  = rsp_cycles_q;
  assign rsp_timeout_o = rsp_timeout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      operator_q    <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      operand_c_q   <= '0;
      vector_mode_q <= '0;
      bmask_a_q     <= '0;
      bmask_b_q     <= '0;
      imm_vec_ext_q <= '0;
      clpx_q        <= '0;
      wait_q        <= '0;
      rsp_result_q  <= '0;
      rsp_cmp_q     <= 1'b0;
      rsp_op_q      <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          operator_q    <= req_op_i;
          operand_a_q   <= req_a_i;
          operand_b_q   <= req_b_i;
          operand_c_q   <= req_c_i;
          vector_mode_q <= req_vector_mode_i;
          bmask_a_q     <= req_bmask_a_i;
          bmask_b_q     <= req_bmask_b_i;
          imm_vec_ext_q <= req_imm_vec_ext_i;
          clpx_q        <= req_clpx_i;
          wait_q        <= '0;
          state_q       <= EXEC;
        end
        EXEC: if (done) begin
          rsp_result_q  <= ready_i ? result_i : 32'd0;
          rsp_cmp_q     <= ready_i && comparison_result_i;
          rsp_op_q      <= operator_q;
          rsp_cycles_q  <= cycles_d;
          rsp_timeout_q <= !ready_i;
          state_q       <= RESP;
        end else begin
          wait_q <= wait_d;
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef ALU_OP_ISSUER_STATS_EN
  logic [31:0] stat_ops_q, stat_busy_q;
  logic [15:0] stat_timeouts_q;
  assign stat_ops_o      = stat_ops_q;
  assign stat_busy_o     = stat_busy_q;
  assign stat_timeouts_o = stat_timeouts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q      <= '0;
      stat_busy_q     <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_ops_q      <= stat_ops_q + 32'(rsp_valid_o && rsp_ready_i);
      stat_busy_q     <= stat_busy_q + 32'(enable_o);
      stat_timeouts_q <= stat_timeouts_q + 16'(timeout);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif
endmodule
